// File: rtl/rand_fetch.sv
// Wishbone master that keeps a local FIFO topped up with numbers from the random
// number generator slave, handling stream selection and seed loading on the way.
module rand_fetch #(
    parameter logic [31:0] RAND_ADDR = 32'hFDFF4000,
    parameter int          DEPTH     = 16,
    parameter logic [7:0]  TIMEOUT   = 8'd255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [9:0]  stream_i,
    input  logic        seed_i,
    input  logic [31:0] seed_z_i,
    input  logic [31:0] seed_w_i,
    input  logic        rd_i,
    output logic [31:0] num_o,
    output logic        valid_o,
    output logic [8:0]  level_o,
    output logic        err_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic [31:0] adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        ack_i
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, STRM, SEEDZ, SEEDW, RD, ADV, GAP} state_t;

    state_t      state, state_n, ret, ret_n, start;
    logic        start_en;
    logic        cyc_n, we_n;
    logic [31:0] adr_n, dat_n;
    logic [7:0]  tmo;
    logic [9:0]  cur_stream;
    logic        strm_dirty, seed_pend, rd_drop;
    logic [31:0] seed_z, seed_w;
    logic        chg, flush, push, pop, tmo_hit, fill_ok, ack_strm;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;

    assign chg      = stream_i != cur_stream;
    assign flush    = chg || seed_i;
    assign tmo_hit  = cyc_o && !ack_i && (tmo == TIMEOUT - 8'd1);
    assign fill_ok  = en_i && !err_o && (level_o < 9'(DEPTH));
    assign ack_strm = (state == STRM) && ack_i;
    // A read whose stream/seed context changed while in flight is discarded.
    assign push     = (state == RD) && ack_i && !rd_drop && !flush;
    assign pop      = rd_i && valid_o;

    assign stb_o   = cyc_o;
    assign sel_o   = cyc_o ? 4'hF : 4'h0;
    assign valid_o = level_o != 9'd0;
    assign num_o   = valid_o ? mem[rp] : 32'h0;

    always_comb begin
        state_n  = state;
        ret_n    = ret;
        cyc_n    = cyc_o;
        we_n     = we_o;
        adr_n    = adr_o;
        dat_n    = m_dat_o;
        start_en = 1'b0;
        start    = IDLE;
        case (state)
            IDLE: begin
                if (seed_pend) begin
                    start_en = 1'b1;
                    start    = strm_dirty ? STRM : SEEDZ;
                end else if (strm_dirty) begin
                    start_en = 1'b1;
                    start    = STRM;
                end else if (fill_ok) begin
                    start_en = 1'b1;
                    start    = RD;
                end
            end
            GAP: begin
                if (ret == IDLE) state_n = IDLE;
                else begin
                    start_en = 1'b1;
                    start    = (ret == SEEDZ && strm_dirty) ? STRM : ret;
                end
            end
            default: begin
                if (ack_i) begin
                    cyc_n   = 1'b0;
                    we_n    = 1'b0;
                    state_n = GAP;
                    case (state)
                        STRM:    ret_n = seed_pend ? SEEDZ : IDLE;
                        SEEDZ:   ret_n = SEEDW;
                        RD:      ret_n = ADV;
                        default: ret_n = IDLE;
                    endcase
                end else if (tmo_hit) begin
                    cyc_n   = 1'b0;
                    we_n    = 1'b0;
                    state_n = IDLE;
                end
            end
        endcase
        if (start_en) begin
            state_n = start;
            cyc_n   = 1'b1;
            we_n    = 1'b1;
            adr_n   = RAND_ADDR;
            dat_n   = 32'h0;
            case (start)
                STRM:  begin adr_n = RAND_ADDR + 32'h4; dat_n = {22'h0, stream_i}; end
                SEEDZ: begin adr_n = RAND_ADDR + 32'h8; dat_n = seed_z; end
                SEEDW: begin adr_n = RAND_ADDR + 32'hC; dat_n = seed_w; end
                RD:    we_n = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            ret        <= IDLE;
            cyc_o      <= 1'b0;
            we_o       <= 1'b0;
            adr_o      <= 32'h0;
            m_dat_o    <= 32'h0;
            tmo        <= 8'h0;
            err_o      <= 1'b0;
            cur_stream <= 10'h0;
            strm_dirty <= 1'b1;
            seed_pend  <= 1'b0;
            seed_z     <= 32'h0;
            seed_w     <= 32'h0;
            rd_drop    <= 1'b0;
        end else begin
            state   <= state_n;
            ret     <= ret_n;
            cyc_o   <= cyc_n;
            we_o    <= we_n;
            adr_o   <= adr_n;
            m_dat_o <= dat_n;
            tmo     <= start_en ? 8'h0 : (cyc_o ? tmo + 8'd1 : tmo);
            if (seed_i)       err_o <= 1'b0;
            else if (tmo_hit) err_o <= 1'b1;
            if (ack_strm) begin
                cur_stream <= m_dat_o[9:0];
                strm_dirty <= stream_i != m_dat_o[9:0];
            end else if (chg) strm_dirty <= 1'b1;
            // Pending is dropped once SEEDZ snapshots the holding regs; any later
            // pulse re-arms it so the newest pair gets written in full.
            if (seed_i) begin
                seed_pend <= 1'b1;
                seed_z    <= seed_z_i;
                seed_w    <= seed_w_i;
            end else if (start_en && start == SEEDZ) seed_pend <= 1'b0;
            else if (tmo_hit && (state == SEEDZ || state == SEEDW)) seed_pend <= 1'b1;
            if (start_en && start == RD)       rd_drop <= 1'b0;
            else if (state == RD && flush)     rd_drop <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp      <= '0;
            rp      <= '0;
            level_o <= 9'd0;
        end else if (flush) begin
            wp      <= '0;
            rp      <= '0;
            level_o <= 9'd0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            if (push && !pop)      level_o <= level_o + 9'd1;
            else if (pop && !push) level_o <= level_o - 9'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wp] <= m_dat_i;
    end
endmodule

// File: tb/tb_rand_fetch.sv
// Directed bench for rand_fetch: a behavioural generator slave with 2-clock ack,
// protocol monitor, and hand-computed expected numbers.
module tb_rand_fetch;
    localparam logic [31:0] BASE = 32'hFDFF4000;

    logic        clk_i = 1'b0, rst_ni = 1'b0, en_i = 1'b0, seed_i = 1'b0, rd_i = 1'b0;
    logic        ack_i = 1'b0;
    logic [9:0]  stream_i = 10'd0;
    logic [31:0] seed_z_i = 32'h0, seed_w_i = 32'h0, m_dat_i = 32'h0;
    logic [31:0] num_o, adr_o, m_dat_o;
    logic        valid_o, err_o, cyc_o, stb_o, we_o;
    logic [8:0]  level_o;
    logic [3:0]  sel_o;

    rand_fetch dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .stream_i(stream_i),
        .seed_i(seed_i), .seed_z_i(seed_z_i), .seed_w_i(seed_w_i), .rd_i(rd_i),
        .num_o(num_o), .valid_o(valid_o), .level_o(level_o), .err_o(err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o),
        .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .ack_i(ack_i)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gval(input logic [31:0] z, input logic [31:0] w);
        return (z << 16) + w;
    endfunction

    task automatic gadv(inout logic [31:0] z, inout logic [31:0] w);
        z = 32'd36969 * {16'h0, z[15:0]} + (z >> 16);
        w = 32'd18000 * {16'h0, w[15:0]} + (w >> 16);
    endtask

    typedef struct {logic we; logic [31:0] adr; logic [31:0] dat;} xact_t;
    xact_t       log_q[$];
    logic [31:0] sz [1024];
    logic [31:0] sw [1024];
    logic [9:0]  sstrm = 10'd0;
    bit          no_ack = 1'b0;
    int          scnt = 0, viol = 0;
    logic        p_cyc = 1'b0, p_we = 1'b0;
    logic [31:0] p_adr = 32'h0, p_dat = 32'h0;

    // Slave + protocol monitor, evaluated on the falling edge.
    initial begin
        for (int i = 0; i < 1024; i++) begin
            sz[i] = 32'(i + 1);
            sw[i] = 32'(i + 100);
        end
        forever begin
            @(negedge clk_i);
            if (stb_o !== cyc_o || sel_o !== (cyc_o ? 4'hF : 4'h0)) viol++;
            if (cyc_o && !p_cyc && p_we) viol++;
            if (cyc_o && p_cyc && (we_o !== p_we || adr_o !== p_adr || m_dat_o !== p_dat)) viol++;
            if (cyc_o && adr_o[31:14] !== BASE[31:14]) viol++;
            p_cyc = cyc_o; p_we = we_o; p_adr = adr_o; p_dat = m_dat_o;
            scnt  = cyc_o ? scnt + 1 : 0;
            ack_i = 1'b0;
            if (scnt == 2 && !no_ack) begin
                ack_i = 1'b1;
                log_q.push_back('{we_o, adr_o, m_dat_o});
                m_dat_i = gval(sz[sstrm], sw[sstrm]);
                if (we_o) begin
                    case (adr_o[3:0])
                        4'h0: begin
                            logic [31:0] z, w;
                            z = sz[sstrm]; w = sw[sstrm];
                            gadv(z, w);
                            sz[sstrm] = z; sw[sstrm] = w;
                        end
                        4'h4: sstrm = m_dat_o[9:0];
                        4'h8: sz[sstrm] = m_dat_o;
                        4'hC: sw[sstrm] = m_dat_o;
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic wait_lvl(input int n, input string tag);
        int k = 0;
        while (level_o < 9'(n) && k < 3000) begin
            @(negedge clk_i);
            k++;
        end
        if (level_o < 9'(n)) chk(tag, 32'(level_o), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rz, rw;
        int idx, cnt, k;

        repeat (3) @(negedge clk_i);
        chk("rst_cyc", 32'(cyc_o), 0);
        chk("rst_stb", 32'(stb_o), 0);
        chk("rst_we", 32'(we_o), 0);
        chk("rst_sel", 32'(sel_o), 0);
        chk("rst_adr", adr_o, 0);
        chk("rst_dat", m_dat_o, 0);
        chk("rst_num", num_o, 0);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_level", 32'(level_o), 0);
        chk("rst_err", 32'(err_o), 0);

        // 1: stream select then fill to DEPTH
        rst_ni = 1'b1; en_i = 1'b1; stream_i = 10'd5;
        wait_lvl(16, "t1_fill");
        repeat (20) @(negedge clk_i);
        chk("t1_nxact", 32'(log_q.size()), 33);
        chk("t1_strm_we", 32'(log_q[0].we), 1);
        chk("t1_strm_adr", log_q[0].adr, BASE + 32'h4);
        chk("t1_strm_dat", log_q[0].dat, 32'd5);
        chk("t1_rd_we", 32'(log_q[1].we), 0);
        chk("t1_rd_adr", log_q[1].adr, BASE);
        chk("t1_adv_we", 32'(log_q[2].we), 1);
        chk("t1_adv_dat", log_q[2].dat, 0);
        chk("t1_idle", 32'(cyc_o), 0);
        chk("t1_level", 32'(level_o), 16);
        chk("t1_head", num_o, 32'h00060069);

        // 2: seed stream 0 with z=17, w=3
        stream_i = 10'd0; seed_z_i = 32'd17; seed_w_i = 32'd3; seed_i = 1'b1;
        @(negedge clk_i);
        seed_i = 1'b0;
        chk("t2_flush", 32'(level_o), 0);
        wait_lvl(1, "t2_fill0");
        chk("t2_v0", num_o, 32'h00110003);
        rd_i = 1'b1;
        @(negedge clk_i);
        rd_i = 1'b0;
        wait_lvl(1, "t2_fill1");
        chk("t2_v1", num_o, 32'h96F9D2F0);
        rd_i = 1'b1;
        @(negedge clk_i);
        rd_i = 1'b0;
        rz = 32'd17; rw = 32'd3;
        gadv(rz, rw); gadv(rz, rw);

        // 3: continuous pops while fills run
        wait_lvl(16, "t3_fill");
        rd_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (valid_o) begin
                chk("t3_seq", num_o, gval(rz, rw));
                gadv(rz, rw);
            end
            @(negedge clk_i);
        end
        rd_i = 1'b0;

        // 4: stream change while a read is in flight
        k = 0;
        do begin
            @(negedge clk_i); #1;
            k++;
        end while (!(cyc_o && !we_o && !ack_i) && k < 500);
        chk("t4_rd_seen", 32'(cyc_o && !we_o), 1);
        idx = log_q.size();
        stream_i = 10'd7;
        @(negedge clk_i);
        chk("t4_flush", 32'(level_o), 0);
        @(negedge clk_i);
        chk("t4_drop", 32'(level_o), 0);
        k = 0;
        while (log_q.size() < idx + 3 && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        chk("t4_nxact", 32'(log_q.size() >= idx + 3), 1);
        if (log_q.size() >= idx + 3) begin
            chk("t4_rd_we", 32'(log_q[idx].we), 0);
            chk("t4_adv_we", 32'(log_q[idx+1].we), 1);
            chk("t4_adv_adr", log_q[idx+1].adr, BASE);
            chk("t4_strm_adr", log_q[idx+2].adr, BASE + 32'h4);
            chk("t4_strm_dat", log_q[idx+2].dat, 32'd7);
        end
        wait_lvl(1, "t4_fill");
        chk("t4_s7", num_o, 32'h0008006B);

        // 5: slave stops acking
        wait_lvl(16, "t5_full");
        repeat (10) @(negedge clk_i);
        no_ack = 1'b1; rd_i = 1'b1;
        @(negedge clk_i);
        rd_i = 1'b0;
        k = 0;
        while (!cyc_o && k < 50) begin
            @(negedge clk_i);
            k++;
        end
        cnt = 0;
        while (cyc_o && cnt < 400) begin
            cnt++;
            @(negedge clk_i);
        end
        chk("t5_tmo_len", 32'(cnt), 255);
        chk("t5_err", 32'(err_o), 1);
        chk("t5_level", 32'(level_o), 15);
        cnt = 0;
        repeat (30) begin
            @(negedge clk_i);
            if (cyc_o) cnt++;
        end
        chk("t5_nofill", 32'(cnt), 0);
        no_ack = 1'b0; seed_z_i = 32'd17; seed_w_i = 32'd3; seed_i = 1'b1;
        @(negedge clk_i);
        seed_i = 1'b0;
        chk("t5_errclr", 32'(err_o), 0);
        wait_lvl(1, "t5_resume_fill");
        chk("t5_resume", num_o, 32'h00110003);

        // 6: asynchronous reset during a bus cycle
        k = 0;
        while (!cyc_o && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        chk("t6_cyc_seen", 32'(cyc_o), 1);
        #1 rst_ni = 1'b0;
        #1;
        chk("t6_cyc", 32'(cyc_o), 0);
        chk("t6_stb", 32'(stb_o), 0);
        chk("t6_we", 32'(we_o), 0);
        chk("t6_level", 32'(level_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        chk("proto", 32'(viol), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
